dco_loop_ctrl: RTL

- Loop-side counterpart of the PFD with calibration: consumes up/down and the frequency-check flags, and regenerates fb_clk.
- Digital loop filter plus a counter-based DCO running on one fast system clock. fb_clk feeds back into the PFD.
- COARSE state handles frequency acquisition from the calibration flags. FINE/LOCKED states handle phase tracking by integrating up/down pulse widths.

---
 rtl/dco_loop_pkg.sv | 34 +++
 rtl/dco_core.sv | 83 ++++++++
 rtl/dco_loop_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dco_loop_pkg.sv
// Shared types, default loop constants and saturating arithmetic for the
// DCO loop controller.
package dco_loop_pkg;

    // Encoding is visible on the loop_state port: IDLE=0, COARSE=1, FINE=2, LOCKED=3.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCoarse = 2'd1,
        StFine   = 2'd2,
        StLocked = 2'd3
    } loop_state_e;

    localparam int unsigned HP_INIT     = 50;
    localparam int unsigned HP_MIN      = 10;
    localparam int unsigned HP_MAX      = 200;
    localparam int unsigned COARSE_STEP = 4;
    localparam int unsigned FINE_STEP   = 1;
    localparam int unsigned DEADBAND    = 2;
    localparam int unsigned LOCK_CNT    = 8;
    localparam int unsigned UNLOCK_TH   = 8;

    // val + delta, clamped to [lo, hi]; never wraps.
    function automatic int sat_add(input int val, input int delta, input int lo, input int hi);
        int sum;
        sum = val + delta;
        if (sum < lo) begin
            sum = lo;
        end else if (sum > hi) begin
            sum = hi;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dco_core.sv
// Counter-based DCO: each fb_clk phase lasts cur_half clk cycles, where
// cur_half is re-latched from ctrl_word only at a toggle, so a control change
// never truncates a phase in flight.
// Optional feature macro: DCO_FRAC_EN (fractional accumulator stretches
// selected phases by one cycle).
module dco_core
    import dco_loop_pkg::*;
#(
    parameter int unsigned HP_W    = 8,
    parameter int unsigned FRAC_W  = 4,
    parameter int unsigned HP_INIT = dco_loop_pkg::HP_INIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [HP_W+FRAC_W-1:0]   ctrl_word,
    output logic                     fb_clk,
    output logic                     toggle_rise
);

    // One extra bit so a fractional carry on top of the integer part cannot overflow.
    localparam int unsigned CntW = HP_W + 1;

    logic [CntW-1:0] half_cnt_q, half_cnt_d;
    logic [CntW-1:0] cur_half_q, cur_half_d;
    logic            fb_clk_q, fb_clk_d;
    logic            toggle;
    logic [HP_W-1:0] ctrl_int;

    assign ctrl_int    = ctrl_word[HP_W+FRAC_W-1:FRAC_W];
    assign toggle      = (half_cnt_q >= cur_half_q);
    assign toggle_rise = toggle & ~fb_clk_q;
    assign fb_clk      = fb_clk_q;

`ifdef DCO_FRAC_EN
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, ctrl_word[FRAC_W-1:0]};
`else
    logic unused_frac;
    assign unused_frac = ^ctrl_word[FRAC_W-1:0];
`endif

    // Next-state: count up within a phase, reload and re-latch the period at a toggle.
    always_comb begin
        half_cnt_d = half_cnt_q + CntW'(1);
        cur_half_d = cur_half_q;
        fb_clk_d   = fb_clk_q;
`ifdef DCO_FRAC_EN
        frac_acc_d = frac_acc_q;
`endif
        if (toggle) begin
            half_cnt_d = CntW'(1);
            fb_clk_d   = ~fb_clk_q;
`ifdef DCO_FRAC_EN
            cur_half_d = {1'b0, ctrl_int} + CntW'(frac_sum[FRAC_W]);
            frac_acc_d = frac_sum[FRAC_W-1:0];
`else
            cur_half_d = {1'b0, ctrl_int};
`endif
        end
    end

    // State registers for the half counter, latched period and output clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt_q <= CntW'(1);
            cur_half_q <= CntW'(HP_INIT);
            fb_clk_q   <= 1'b0;
`ifdef DCO_FRAC_EN
            frac_acc_q <= '0;
`endif
        end else begin
            half_cnt_q <= half_cnt_d;
            cur_half_q <= cur_half_d;
            fb_clk_q   <= fb_clk_d;
`ifdef DCO_FRAC_EN
            frac_acc_q <= frac_acc_d;
`endif
        end
    end

endmodule

// File: rtl/dco_loop_ctrl.sv
// Loop controller: synchronises PFD outputs, acquires frequency from the
// calibration verdicts (COARSE), then tracks phase by integrating up/down
// pulse widths per fb_clk period (FINE/LOCKED) and steers the DCO.
// Optional feature macro: DCO_FRAC_EN (fine steps in fractional LSBs).
module dco_loop_ctrl
    import dco_loop_pkg::*;
#(
    parameter int unsigned HP_W        = 8,
    parameter int unsigned FRAC_W      = 4,
    parameter int unsigned HP_INIT     = dco_loop_pkg::HP_INIT,
    parameter int unsigned HP_MIN      = dco_loop_pkg::HP_MIN,
    parameter int unsigned HP_MAX      = dco_loop_pkg::HP_MAX,
    parameter int unsigned COARSE_STEP = dco_loop_pkg::COARSE_STEP,
    parameter int unsigned FINE_STEP   = dco_loop_pkg::FINE_STEP,
    parameter int unsigned DEADBAND    = dco_loop_pkg::DEADBAND,
    parameter int unsigned LOCK_CNT    = dco_loop_pkg::LOCK_CNT,
    parameter int unsigned UNLOCK_TH   = dco_loop_pkg::UNLOCK_TH,
    parameter int unsigned CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up,
    input  logic                   down,
    input  logic                   freq_check_done,
    input  logic                   ref_clk_is_faster,
    input  logic                   ref_clk_is_slower,
    input  logic                   calibration_done,
    output logic                   fb_clk,
    output logic [HP_W+FRAC_W-1:0] ctrl_word,
    output logic [1:0]             loop_state,
    output logic                   locked
);

    localparam int unsigned LockW = $clog2(LOCK_CNT + 1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [5:0] sync1_q, sync2_q;
    logic       fcd_s_q;
    logic       up_s, down_s, fcd_s, faster_s, slower_s, cal_s;
    logic       fcd_rise;

    assign {cal_s, slower_s, faster_s, fcd_s, down_s, up_s} = sync2_q;
    assign fcd_rise = fcd_s & ~fcd_s_q;

    // Two-flop synchronisers plus one extra stage for verdict edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fcd_s_q <= 1'b0;
        end else begin
            sync1_q <= {calibration_done, ref_clk_is_slower, ref_clk_is_faster,
                        freq_check_done, down, up};
            sync2_q <= sync1_q;
            fcd_s_q <= fcd_s;
        end
    end

    // ------------------------------------------------------------------
    // DCO
    // ------------------------------------------------------------------
    logic toggle_rise;

    dco_core #(
        .HP_W    (HP_W),
        .FRAC_W  (FRAC_W),
        .HP_INIT (HP_INIT)
    ) u_dco_core (
        .clk         (clk),
        .rst         (rst),
        .ctrl_word   (ctrl_word),
        .fb_clk      (fb_clk),
        .toggle_rise (toggle_rise)
    );

    // ------------------------------------------------------------------
    // Window integrator
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      up_cnt_q, up_cnt_d;
    logic [CNT_W-1:0]      dn_cnt_q, dn_cnt_d;
    logic signed [CNT_W:0] net;
    int                    net_val;
    int                    net_abs;
    logic                  win_clr;

    assign net = $signed({1'b0, up_cnt_q}) - $signed({1'b0, dn_cnt_q});

    // Signed window result and its magnitude as plain integers.
    always_comb begin
        net_val = int'(net);
        net_abs = (net_val < 0) ? -net_val : net_val;
    end

    // Saturating pulse-width counters; overlap cycles are PFD reset and ignored.
    always_comb begin
        up_cnt_d = up_cnt_q;
        dn_cnt_d = dn_cnt_q;
        if (up_s && !down_s && (up_cnt_q != '1)) begin
            up_cnt_d = up_cnt_q + CNT_W'(1);
        end
        if (down_s && !up_s && (dn_cnt_q != '1)) begin
            dn_cnt_d = dn_cnt_q + CNT_W'(1);
        end
        if (toggle_rise || win_clr) begin
            up_cnt_d = '0;
            dn_cnt_d = '0;
        end
    end

    // Window counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
        end else begin
            up_cnt_q <= up_cnt_d;
            dn_cnt_q <= dn_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Loop FSM
    // ------------------------------------------------------------------
    loop_state_e      state_q, state_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    int               coarse_delta;
    int               fine_delta;

    // Next state, lock counting and the requested control-word step.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        win_clr      = 1'b0;
        coarse_delta = 0;
        fine_delta   = 0;
        case (state_q)
            StIdle: begin
                state_d = StCoarse;
            end
            StCoarse: begin
                if (fcd_rise) begin
                    if (faster_s && !slower_s) begin
                        coarse_delta = -int'(COARSE_STEP);
                    end else if (slower_s && !faster_s) begin
                        coarse_delta = int'(COARSE_STEP);
                    end
                end
                if (cal_s) begin
                    state_d    = StFine;
                    win_clr    = 1'b1;
                    lock_cnt_d = '0;
                end
            end
            StFine, StLocked: begin
                // Recalibration wins over a window ending in the same cycle.
                if (!cal_s) begin
                    state_d    = StCoarse;
                    lock_cnt_d = '0;
                end else if (toggle_rise) begin
                    if (net_val > int'(DEADBAND)) begin
                        fine_delta = -int'(FINE_STEP);
                    end else if (net_val < -int'(DEADBAND)) begin
                        fine_delta = int'(FINE_STEP);
                    end
                    if (state_q == StFine) begin
                        if (net_abs <= int'(DEADBAND)) begin
                            if (int'(lock_cnt_q) + 1 >= int'(LOCK_CNT)) begin
                                state_d    = StLocked;
                                lock_cnt_d = LockW'(LOCK_CNT);
                            end else begin
                                lock_cnt_d = lock_cnt_q + LockW'(1);
                            end
                        end else begin
                            lock_cnt_d = '0;
                        end
                    end else if (net_abs > int'(UNLOCK_TH)) begin
                        state_d    = StFine;
                        lock_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and lock counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Control word
    // ------------------------------------------------------------------
    logic [HP_W-1:0] ctrl_int_q, ctrl_int_d;

`ifdef DCO_FRAC_EN
    localparam int FracOne = 1 << FRAC_W;

    logic [FRAC_W-1:0] ctrl_frac_q, ctrl_frac_d;
    int                full;

    assign ctrl_word = {ctrl_int_q, ctrl_frac_q};
`else
    assign ctrl_word = {ctrl_int_q, {FRAC_W{1'b0}}};
`endif

    // Apply the requested step with saturation on the integer part.
    always_comb begin
        ctrl_int_d = ctrl_int_q;
`ifdef DCO_FRAC_EN
        ctrl_frac_d = ctrl_frac_q;
        full        = 0;
`endif
        if (coarse_delta != 0) begin
            ctrl_int_d = HP_W'(sat_add(int'(ctrl_int_q), coarse_delta,
                                       int'(HP_MIN), int'(HP_MAX)));
`ifdef DCO_FRAC_EN
            if (ctrl_int_d == HP_W'(HP_MAX)) begin
                ctrl_frac_d = '0;
            end
`endif
        end else if (fine_delta != 0) begin
`ifdef DCO_FRAC_EN
            // Clamping the full word at HP_MAX.0 zeroes the fraction as a side effect.
            full = sat_add(int'(ctrl_int_q) * FracOne + int'(ctrl_frac_q), fine_delta,
                           int'(HP_MIN) * FracOne, int'(HP_MAX) * FracOne);
            ctrl_int_d  = HP_W'(full / FracOne);
            ctrl_frac_d = FRAC_W'(full % FracOne);
`else
            ctrl_int_d = HP_W'(sat_add(int'(ctrl_int_q), fine_delta,
                                       int'(HP_MIN), int'(HP_MAX)));
`endif
        end
    end

    // Control word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_int_q <= HP_W'(HP_INIT);
`ifdef DCO_FRAC_EN
            ctrl_frac_q <= '0;
`endif
        end else begin
            ctrl_int_q <= ctrl_int_d;
`ifdef DCO_FRAC_EN
            ctrl_frac_q <= ctrl_frac_d;
`endif
        end
    end

    assign loop_state = state_q;
    assign locked     = (state_q == StLocked);

endmodule
